// File: rtl/conversor_hex_binario_if.sv
// rtl/conversor_hex_binario_if.sv - digit entry / result bundle for the hex-to-binary converter
interface conversor_hex_binario_if;
  logic [3:0] digito;
  logic       digito_valido;
  logic       limpar;
  logic [7:0] Saida;
  logic       saida_valida;
  logic [3:0] H;
  logic       aguardando_baixo;
  logic       erro_timeout;

  modport master (
    output digito, digito_valido, limpar,
    input  Saida, saida_valida, H, aguardando_baixo, erro_timeout
  );

  modport slave (
    input  digito, digito_valido, limpar,
    output Saida, saida_valida, H, aguardando_baixo, erro_timeout
  );
endinterface

// File: rtl/conversor_hex_binario.sv
// rtl/conversor_hex_binario.sv - assembles two hex digits (high first) into an 8-bit value
// with an entry timeout between digits and a synchronous abort.
module conversor_hex_binario #(
  parameter int TIMEOUT = 1000
) (
  input  logic                    clk,
  input  logic                    reset,
  conversor_hex_binario_if.slave  bus
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic {
    ESPERA_ALTO  = 1'b0,
    ESPERA_BAIXO = 1'b1
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;

  always_ff @(posedge clk) begin
    if (reset) begin
      state                <= ESPERA_ALTO;
      timer                <= '0;
      bus.Saida            <= 8'h00;
      bus.H                <= 4'h0;
      bus.saida_valida     <= 1'b0;
      bus.aguardando_baixo <= 1'b0;
      bus.erro_timeout     <= 1'b0;
    end else begin
      bus.saida_valida <= 1'b0;
      bus.erro_timeout <= 1'b0;
      if (bus.limpar) begin
        state                <= ESPERA_ALTO;
        timer                <= '0;
        bus.aguardando_baixo <= 1'b0;
      end else begin
        case (state)
          ESPERA_ALTO: begin
            if (bus.digito_valido) begin
              bus.H                <= bus.digito;
              timer                <= '0;
              state                <= ESPERA_BAIXO;
              bus.aguardando_baixo <= 1'b1;
            end
          end
          ESPERA_BAIXO: begin
            // A low digit on the final timer cycle still wins over the timeout.
            if (bus.digito_valido) begin
              bus.Saida            <= {bus.H, bus.digito};
              bus.saida_valida     <= 1'b1;
              state                <= ESPERA_ALTO;
              bus.aguardando_baixo <= 1'b0;
            end else if (timer == TIMER_LAST) begin
              bus.erro_timeout     <= 1'b1;
              timer                <= '0;
              state                <= ESPERA_ALTO;
              bus.aguardando_baixo <= 1'b0;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          default: begin
            state                <= ESPERA_ALTO;
            bus.aguardando_baixo <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_conversor_hex_binario.sv
// tb/tb_conversor_hex_binario.sv - scoreboard bench for conversor_hex_binario
module tb_conversor_hex_binario;

  localparam int TIMEOUT = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  conversor_hex_binario_if bus();

  conversor_hex_binario #(.TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic       sv;
    logic       et;
    logic       ab;
    logic [3:0] h;
    logic [7:0] saida;
  } exp_t;

  exp_t       state_q[$];
  logic [7:0] resp_q[$];
  int checks   = 0;
  int failures = 0;

  // Reference: pending high digit (-1 = none), idle cycles since it arrived.
  int pend   = -1;
  int waited = 0;
  int last   = 0;
  int hdisp  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic cyc(input logic r, input logic l, input logic v, input logic [3:0] d);
    exp_t e;
    @(negedge clk);
    #1;
    reset             = r;
    bus.limpar        = l;
    bus.digito_valido = v;
    bus.digito        = d;
    e.sv = 1'b0;
    e.et = 1'b0;
    if (r) begin
      pend = -1; last = 0; hdisp = 0;
    end else if (l) begin
      pend = -1;
    end else if (v) begin
      if (pend < 0) begin
        pend = int'(d); hdisp = int'(d); waited = 0;
      end else begin
        last = pend * 16 + int'(d);
        resp_q.push_back(8'(last));
        e.sv = 1'b1;
        pend = -1;
      end
    end else if (pend >= 0) begin
      waited++;
      if (waited == TIMEOUT) begin
        e.et = 1'b1;
        pend = -1;
      end
    end
    e.ab    = (pend >= 0);
    e.h     = 4'(hdisp);
    e.saida = 8'(last);
    state_q.push_back(e);
  endtask

  task automatic strobe(input logic [3:0] d);
    cyc(1'b0, 1'b0, 1'b1, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 4'(i));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (state_q.size() > 0) begin
      e = state_q.pop_front();
      chk("saida_valida", 32'(bus.saida_valida), 32'(e.sv));
      chk("erro_timeout", 32'(bus.erro_timeout), 32'(e.et));
      chk("aguardando_baixo", 32'(bus.aguardando_baixo), 32'(e.ab));
      chk("H", 32'(bus.H), 32'(e.h));
      chk("Saida_held", 32'(bus.Saida), 32'(e.saida));
      if (bus.saida_valida === 1'b1) begin
        if (resp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pulse actual=%0h required=none", bus.Saida);
        end else begin
          chk("Saida_resp", 32'(bus.Saida), 32'(resp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    reset             = 1'b1;
    bus.limpar        = 1'b0;
    bus.digito_valido = 1'b0;
    bus.digito        = 4'h0;
    // Reset with strobes present: strobes must be ignored.
    cyc(1'b1, 1'b0, 1'b1, 4'hE);
    cyc(1'b1, 1'b0, 1'b1, 4'h6);
    idle(2);
    // Basic A then 5 two cycles later.
    strobe(4'hA); idle(1); strobe(4'h5); idle(2);
    // Boundaries and back-to-back.
    strobe(4'h0); strobe(4'h0); idle(1);
    strobe(4'hF); strobe(4'hF); idle(1);
    strobe(4'h3); strobe(4'hC); strobe(4'h1); strobe(4'h8);
    // Timeout, then next strobe is a high digit.
    strobe(4'h7); idle(6);
    strobe(4'hB); strobe(4'h4); idle(1);
    // Timeout race: low digit on last timer cycle.
    strobe(4'h7); idle(3); strobe(4'h2); idle(2);
    // Abort together with strobe, then a fresh entry.
    strobe(4'h9); cyc(1'b0, 1'b1, 1'b1, 4'h1); idle(1);
    strobe(4'h1); strobe(4'h2); idle(1);
    // Reset mid-entry.
    strobe(4'hA); strobe(4'h5); strobe(4'h3);
    cyc(1'b1, 1'b0, 1'b0, 4'h0);
    strobe(4'h4); strobe(4'h0); idle(1);
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom % 97) == 0, ($urandom % 29) == 0, ($urandom % 3) == 0, 4'($urandom));
    end
    idle(2);
    @(negedge clk);
    @(negedge clk);
    chk("resp_queue_drained", 32'(resp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
